// File: rtl/fpu_uart_pkg.sv
// Shared types and constants for the UART-to-FPU packet receiver.
// The bit-level FSM state encoding and packet framing limits live here.
package fpu_uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam int PKT_BYTES        = 5;
   localparam int MIN_CLKS_PER_BIT = 4;
   localparam int TIMEOUT_BITS     = 20;

   // Very short bit periods leave no room for a mid-bit sample, so floor them.
   function automatic logic [15:0] clamp_cpb(input logic [15:0] cpb);
      return (cpb < 16'(MIN_CLKS_PER_BIT)) ? 16'(MIN_CLKS_PER_BIT) : cpb;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling FSM,
// registered byte_valid / frame_err pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on rxs
// START     | counting to the middle of the start bit, glitch check
// DATA      | sampling 8 data bits LSB first, one per bit period
// STOP      | sampling the stop bit; high = good byte, low = frame error
// WAIT_HIGH | after a frame error, hold until the line returns high
module uart_rx_byte
   import fpu_uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst_l,
   input  logic        r_Rx_Serial,
   input  logic [15:0] CLKS_PER_BIT,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        frame_err,
   output logic        rx_idle,
   output logic [15:0] clks_bit
);

   logic        sync_1;
   logic        rxs;
   logic [1:0]  live;
   logic        seen_high;
   rx_state_t   state;
   rx_state_t   state_nxt;
   logic [15:0] cnt;
   logic [15:0] c_lat;
   logic [15:0] c_in;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        tick;
   logic        start_det;
   logic        shift_en;
   logic        good_stop;
   logic        bad_stop;

   assign c_in     = clamp_cpb(CLKS_PER_BIT);
   assign tick     = (cnt == 16'd0);
   assign rx_idle  = (state == IDLE);
   assign clks_bit = c_lat;

   // Synchronizer resets high; a start is only accepted once rxs has
   // genuinely been seen high after reset, so a line stuck low is ignored.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sync_1    <= 1'b1;
         rxs       <= 1'b1;
         live      <= 2'b00;
         seen_high <= 1'b0;
      end else begin
         sync_1 <= r_Rx_Serial;
         rxs    <= sync_1;
         live   <= {live[0], 1'b1};
         if (live[1] && rxs) seen_high <= 1'b1;
      end
   end

   assign start_det = seen_high && !rxs;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_det) state_nxt = START;
         START:     if (tick) state_nxt = rxs ? IDLE : DATA;
         DATA:      if (tick && (bit_idx == 3'd7)) state_nxt = STOP;
         STOP:      if (tick) state_nxt = rxs ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rxs) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      shift_en  = 1'b0;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
      case (state)
         DATA: shift_en = tick;
         STOP: begin
            good_stop = tick && rxs;
            bad_stop  = tick && !rxs;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt        <= 16'd0;
         c_lat      <= 16'd0;
         bit_idx    <= 3'd0;
         shreg      <= 8'd0;
         byte_valid <= 1'b0;
         byte_data  <= 8'd0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= good_stop;
         frame_err  <= bad_stop;
         if (good_stop) byte_data <= shreg;
         if (shift_en) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         case (state)
            IDLE: begin
               if (start_det) begin
                  c_lat   <= c_in;
                  cnt     <= (c_in >> 1) - 16'd1;
                  bit_idx <= 3'd0;
               end
            end
            START, DATA, STOP: begin
               if (tick) cnt <= c_lat - 16'd1;
               else      cnt <= cnt - 16'd1;
            end
            default: cnt <= 16'd0;
         endcase
      end
   end

endmodule

// File: rtl/fpu_uart_pkt_rx.sv
// Assembles 5-byte FPU command packets (opcode, op_a, op_b) from the UART
// byte stream, with an inter-byte timeout and a valid/ready output stage.
module fpu_uart_pkt_rx
   import fpu_uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst_l,
   input  logic        r_Rx_Serial,
   input  logic [15:0] CLKS_PER_BIT,
   output logic        pkt_valid,
   input  logic        pkt_ready,
   output logic [7:0]  pkt_opcode,
   output logic [15:0] pkt_op_a,
   output logic [15:0] pkt_op_b,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        frame_err,
   output logic        overrun
);

   logic        rx_idle;
   logic [15:0] clks_bit;
   logic [2:0]  idx;
   logic [31:0] shadow;
   logic [20:0] to_cnt;
   logic [20:0] to_reload;
   logic        complete;
   logic        load;
   logic        timeout;

   uart_rx_byte u_rx (
      .clk          (clk),
      .rst_l        (rst_l),
      .r_Rx_Serial  (r_Rx_Serial),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .frame_err    (frame_err),
      .rx_idle      (rx_idle),
      .clks_bit     (clks_bit)
   );

   assign complete  = byte_valid && (idx == 3'(PKT_BYTES - 1));
   assign load      = complete && (!pkt_valid || pkt_ready);
   assign to_reload = 21'(clks_bit) * 21'(TIMEOUT_BITS);
   assign timeout   = (idx != 3'd0) && (to_cnt == 21'd0) && rx_idle;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         idx    <= 3'd0;
         shadow <= 32'd0;
      end else if (frame_err || timeout) begin
         idx    <= 3'd0;
         shadow <= 32'd0;
      end else if (byte_valid) begin
         if (complete) begin
            idx <= 3'd0;
         end else begin
            idx    <= idx + 3'd1;
            shadow <= {shadow[23:0], byte_data};
         end
      end
   end

   // Counts down from the last good byte; parks at zero until a new byte.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l)                  to_cnt <= 21'd0;
      else if (byte_valid)         to_cnt <= to_reload;
      else if (to_cnt != 21'd0)    to_cnt <= to_cnt - 21'd1;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         pkt_valid  <= 1'b0;
         pkt_opcode <= 8'd0;
         pkt_op_a   <= 16'd0;
         pkt_op_b   <= 16'd0;
         overrun    <= 1'b0;
      end else begin
         overrun <= complete && pkt_valid && !pkt_ready;
         if (load) begin
            pkt_valid  <= 1'b1;
            pkt_opcode <= shadow[31:24];
            pkt_op_a   <= shadow[23:8];
            pkt_op_b   <= {shadow[7:0], byte_data};
         end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
         end
      end
   end

endmodule
